// File: rtl/cs_dac_i2s_tx.sv
// I2S transmitter for CS4344-family DACs: serialises a double-buffered stereo frame, MSB first.
// Optional CS_DAC_TX_UNDERRUN_REPEAT_EN: an underrun repeats the last transmitted frame.
module cs_dac_i2s_tx #(
  parameter int unsigned AUDIO_WIDTH_P = 24,
  parameter int unsigned SLOT_WIDTH_P  = 32,
  parameter int unsigned SCLK_DIV_P    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cr_enable,
  input  logic [AUDIO_WIDTH_P-1:0] dac_data,
  input  logic                     dac_valid,
  output logic                     dac_ready,
  input  logic                     dac_last,
  output logic                     i2s_sclk,
  output logic                     i2s_lrck,
  output logic                     i2s_sdata,
  output logic                     sr_underrun,
  output logic                     sr_seq_error,
  output logic [15:0]              sr_underrun_count
);

  localparam int unsigned FrameBits = 2 * SLOT_WIDTH_P;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (SCLK_DIV_P > 1) ? $clog2(SCLK_DIV_P) : 1;

  localparam logic [BitW-1:0] LastBit  = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotBits = BitW'(SLOT_WIDTH_P);
  localparam logic [BitW-1:0] AudBits  = BitW'(AUDIO_WIDTH_P);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCLK_DIV_P - 1);
  localparam logic [AUDIO_WIDTH_P-1:0] MsbMask = {1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};

  logic [DivW-1:0]          div_q, div_d;
  logic                     sclk_q, sclk_d;
  logic                     lrck_q, lrck_d;
  logic                     sdata_q, sdata_d;
  logic [BitW-1:0]          bit_q, bit_d;
  logic [AUDIO_WIDTH_P-1:0] left_buf_q, left_buf_d;
  logic [AUDIO_WIDTH_P-1:0] right_buf_q, right_buf_d;
  logic                     full_q, full_d;
  logic                     exp_ch_q, exp_ch_d;
  logic [AUDIO_WIDTH_P-1:0] left_sh_q, left_sh_d;
  logic [AUDIO_WIDTH_P-1:0] right_sh_q, right_sh_d;
  logic                     urun_q, urun_d;
  logic                     seq_err_q, seq_err_d;
  logic [15:0]              urun_cnt_q, urun_cnt_d;

  logic                     tick;
  logic                     fall_tick;
  logic                     frame_start;
  logic                     accept;
  logic [BitW-1:0]          bit_nxt;
  logic                     chan_nxt;
  logic [BitW-1:0]          pos;
  logic [AUDIO_WIDTH_P-1:0] sel_sample;
  logic [AUDIO_WIDTH_P-1:0] sel_mask;
  logic                     bit_out;

  assign tick        = cr_enable && (div_q == DivLast);
  assign fall_tick   = tick && sclk_q;
  assign bit_nxt     = (bit_q == LastBit) ? '0 : bit_q + BitW'(1);
  assign frame_start = fall_tick && (bit_nxt == '0);
  assign chan_nxt    = (bit_nxt >= SlotBits);
  assign pos         = chan_nxt ? (bit_nxt - SlotBits) : bit_nxt;
  assign sel_sample  = chan_nxt ? right_sh_q : left_sh_q;

  // Slot position 0 is the I2S one-bit delay; positions 1..W walk MSB to LSB.
  assign sel_mask = MsbMask >> (pos - BitW'(1));
  assign bit_out  = (pos != '0) && (pos <= AudBits) && (|(sel_sample & sel_mask));

  assign dac_ready = cr_enable && !full_q;
  assign accept    = dac_valid && dac_ready;

  always_comb begin
    div_d       = div_q;
    sclk_d      = sclk_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    bit_d       = bit_q;
    left_buf_d  = left_buf_q;
    right_buf_d = right_buf_q;
    full_d      = full_q;
    exp_ch_d    = exp_ch_q;
    left_sh_d   = left_sh_q;
    right_sh_d  = right_sh_q;
    urun_d      = 1'b0;
    seq_err_d   = 1'b0;
    urun_cnt_d  = urun_cnt_q;

    if (!cr_enable) begin
      div_d       = '0;
      sclk_d      = 1'b0;
      lrck_d      = 1'b0;
      sdata_d     = 1'b0;
      bit_d       = LastBit;
      left_buf_d  = '0;
      right_buf_d = '0;
      full_d      = 1'b0;
      exp_ch_d    = 1'b0;
`ifdef CS_DAC_TX_UNDERRUN_REPEAT_EN
      left_sh_d   = left_sh_q;
      right_sh_d  = right_sh_q;
`else
      left_sh_d   = '0;
      right_sh_d  = '0;
`endif
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        sclk_d = ~sclk_q;
      end
      if (fall_tick) begin
        bit_d   = bit_nxt;
        lrck_d  = chan_nxt;
        sdata_d = bit_out;
      end

      // Uses the pre-update full flag, so a right sample landing on this edge waits a frame.
      if (frame_start) begin
        if (full_q) begin
          left_sh_d  = left_buf_q;
          right_sh_d = right_buf_q;
          full_d     = 1'b0;
        end else begin
`ifdef CS_DAC_TX_UNDERRUN_REPEAT_EN
          left_sh_d  = left_sh_q;
          right_sh_d = right_sh_q;
`else
          left_sh_d  = '0;
          right_sh_d = '0;
`endif
          urun_d = 1'b1;
          if (urun_cnt_q != 16'hFFFF) begin
            urun_cnt_d = urun_cnt_q + 16'd1;
          end
        end
      end

      if (accept) begin
        if (dac_last == exp_ch_q) begin
          if (!exp_ch_q) begin
            left_buf_d = dac_data;
            exp_ch_d   = 1'b1;
          end else begin
            right_buf_d = dac_data;
            exp_ch_d    = 1'b0;
            full_d      = 1'b1;
          end
        end else begin
          seq_err_d = 1'b1;
          // A stray left while waiting for right resynchronises on the newest left.
          if (!dac_last) begin
            left_buf_d = dac_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      bit_q       <= LastBit;
      left_buf_q  <= '0;
      right_buf_q <= '0;
      full_q      <= 1'b0;
      exp_ch_q    <= 1'b0;
      left_sh_q   <= '0;
      right_sh_q  <= '0;
      urun_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      urun_cnt_q  <= '0;
    end else begin
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      bit_q       <= bit_d;
      left_buf_q  <= left_buf_d;
      right_buf_q <= right_buf_d;
      full_q      <= full_d;
      exp_ch_q    <= exp_ch_d;
      left_sh_q   <= left_sh_d;
      right_sh_q  <= right_sh_d;
      urun_q      <= urun_d;
      seq_err_q   <= seq_err_d;
      urun_cnt_q  <= urun_cnt_d;
    end
  end

  assign i2s_sclk          = sclk_q;
  assign i2s_lrck          = lrck_q;
  assign i2s_sdata         = sdata_q;
  assign sr_underrun       = urun_q;
  assign sr_seq_error      = seq_err_q;
  assign sr_underrun_count = urun_cnt_q;

endmodule
